// File: rtl/vm2002_pkg.sv
// Shared types for the vm2002 vending controller: coin denominations, their
// values in cents and the change-dispenser FSM states.
package vm2002_pkg;

  typedef enum logic [1:0] {
    NICKEL  = 2'd0,
    DIME    = 2'd1,
    QUARTER = 2'd2,
    DOLLAR  = 2'd3
  } coin_t;

  localparam int unsigned COIN_VAL_W = 7;

  localparam logic [COIN_VAL_W-1:0] NICKEL_CENTS  = 7'd5;
  localparam logic [COIN_VAL_W-1:0] DIME_CENTS    = 7'd10;
  localparam logic [COIN_VAL_W-1:0] QUARTER_CENTS = 7'd25;
  localparam logic [COIN_VAL_W-1:0] DOLLAR_CENTS  = 7'd100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    ISSUE = 3'd2,
    FIN   = 3'd3,
    FAULT = 3'd4
  } change_state_t;

  function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_t c);
    logic [COIN_VAL_W-1:0] v;
    case (c)
      NICKEL:  v = NICKEL_CENTS;
      DIME:    v = DIME_CENTS;
      QUARTER: v = QUARTER_CENTS;
      default: v = DOLLAR_CENTS;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm2002_coin_inventory.sv
// Per-denomination coin stock for the change dispenser: saturating counters
// with restock and single-coin decrement, plus nonzero flags for selection.
module vm2002_coin_inventory
  import vm2002_pkg::*;
#(
  parameter int unsigned INV_W    = 8,
  parameter int unsigned INIT_INV = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restock_valid,
  input  coin_t            restock_coin,
  input  logic [INV_W-1:0] restock_cnt,
  input  logic             dec_valid,
  input  coin_t            dec_coin,
  output logic [2:0]       nonzero
);

  logic [INV_W-1:0] cnt   [3];
  logic [INV_W-1:0] cnt_d [3];

  // Restock is added before the decrement so a same-cycle collision yields
  // cnt + restock - 1, with saturation applied to the combined result.
  always_comb begin
    logic [INV_W:0] sum;
    sum   = '0;
    cnt_d = cnt;
    for (int unsigned i = 0; i < 3; i++) begin
      sum = {1'b0, cnt[i]};
      if (restock_valid && restock_coin == coin_t'(i[1:0]))
        sum = sum + {1'b0, restock_cnt};
      if (dec_valid && dec_coin == coin_t'(i[1:0]) && sum != '0)
        sum = sum - {{INV_W{1'b0}}, 1'b1};
      cnt_d[i] = sum[INV_W] ? '1 : sum[INV_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= INV_W'(INIT_INV);
    end else begin
      cnt <= cnt_d;
    end
  end

  always_comb begin
    nonzero = '0;
    for (int unsigned i = 0; i < 3; i++) nonzero[i] = |cnt[i];
  end

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Pays a refund balance out as coins, largest denomination first, to a hopper
// over a valid/ready handshake; flags shortfall and hopper timeout.
module vm2002_change_dispenser
  import vm2002_pkg::*;
#(
  parameter int unsigned BAL_W          = 16,
  parameter int unsigned INV_W          = 8,
  parameter int unsigned INIT_INV       = 20,
  parameter int unsigned HOPPER_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refund_req,
  input  logic [BAL_W-1:0] refund_amt,
  input  logic             restock_valid,
  input  coin_t            restock_coin,
  input  logic [INV_W-1:0] restock_cnt,
  output logic             coin_valid,
  output coin_t            coin_out,
  input  logic             coin_ready,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [BAL_W-1:0] remaining
);

  localparam int unsigned WAIT_W = $clog2(HOPPER_TIMEOUT + 1);

  change_state_t    state, state_d;
  logic [BAL_W-1:0] rem_d;
  logic             short_d;
  coin_t            coin_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic             dec_valid;
  logic [2:0]       nonzero;
  logic             pick_ok;
  coin_t            pick_coin;

  vm2002_coin_inventory #(
    .INV_W    (INV_W),
    .INIT_INV (INIT_INV)
  ) u_inv (
    .clk           (clk),
    .rst           (rst),
    .restock_valid (restock_valid),
    .restock_coin  (restock_coin),
    .restock_cnt   (restock_cnt),
    .dec_valid     (dec_valid),
    .dec_coin      (coin_out),
    .nonzero       (nonzero)
  );

  // Greedy selection; a coin qualifies only if it fits, so payout never underflows.
  always_comb begin
    pick_ok   = 1'b1;
    pick_coin = NICKEL;
    if (nonzero[QUARTER] && remaining >= BAL_W'(coin_value(QUARTER)))
      pick_coin = QUARTER;
    else if (nonzero[DIME] && remaining >= BAL_W'(coin_value(DIME)))
      pick_coin = DIME;
    else if (nonzero[NICKEL] && remaining >= BAL_W'(coin_value(NICKEL)))
      pick_coin = NICKEL;
    else
      pick_ok = 1'b0;
  end

  always_comb begin
    state_d   = state;
    rem_d     = remaining;
    short_d   = short;
    coin_d    = coin_out;
    wait_d    = wait_cnt;
    dec_valid = 1'b0;
    case (state)
      IDLE: begin
        if (refund_req) begin
          rem_d   = refund_amt;
          short_d = 1'b0;
          state_d = PICK;
        end
      end
      PICK: begin
        wait_d = '0;
        if (remaining == '0) begin
          state_d = FIN;
        end else if (pick_ok) begin
          coin_d  = pick_coin;
          state_d = ISSUE;
        end else begin
          short_d = 1'b1;
          state_d = FIN;
        end
      end
      ISSUE: begin
        if (coin_ready) begin
          rem_d     = remaining - BAL_W'(coin_value(coin_out));
          dec_valid = 1'b1;
          state_d   = PICK;
        end else if (wait_cnt == WAIT_W'(HOPPER_TIMEOUT - 1)) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_cnt + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      short     <= 1'b0;
      coin_out  <= NICKEL;
      wait_cnt  <= '0;
    end else begin
      state     <= state_d;
      remaining <= rem_d;
      short     <= short_d;
      coin_out  <= coin_d;
      wait_cnt  <= wait_d;
    end
  end

  assign coin_valid = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign fault      = (state == FAULT);

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Directed bench for vm2002_change_dispenser: a refund vector table on a
// default-stock instance plus hand sequences on a single-coin-stock instance.
module tb_vm2002_change_dispenser;
  import vm2002_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        req    [2];
  logic [15:0] amt_i  [2];
  logic        rsv    [2];
  coin_t       rsc    [2];
  logic [7:0]  rsn    [2];
  logic        rdy    [2];
  logic        cv     [2];
  coin_t       co     [2];
  logic        bsy    [2];
  logic        dn     [2];
  logic        sh     [2];
  logic        flt    [2];
  logic [15:0] rem    [2];

  int checks = 0;
  int errors = 0;

  vm2002_change_dispenser #(
    .BAL_W(16), .INV_W(8), .INIT_INV(20), .HOPPER_TIMEOUT(255)
  ) dut0 (
    .clk(clk), .rst(rst[0]), .refund_req(req[0]), .refund_amt(amt_i[0]),
    .restock_valid(rsv[0]), .restock_coin(rsc[0]), .restock_cnt(rsn[0]),
    .coin_valid(cv[0]), .coin_out(co[0]), .coin_ready(rdy[0]),
    .busy(bsy[0]), .done(dn[0]), .short(sh[0]), .fault(flt[0]), .remaining(rem[0])
  );

  vm2002_change_dispenser #(
    .BAL_W(16), .INV_W(8), .INIT_INV(1), .HOPPER_TIMEOUT(255)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .refund_req(req[1]), .refund_amt(amt_i[1]),
    .restock_valid(rsv[1]), .restock_coin(rsc[1]), .restock_cnt(rsn[1]),
    .coin_valid(cv[1]), .coin_out(co[1]), .coin_ready(rdy[1]),
    .busy(bsy[1]), .done(dn[1]), .short(sh[1]), .fault(flt[1]), .remaining(rem[1])
  );

  typedef struct packed {
    logic [15:0] amt;
    logic [3:0]  ncoins;
    logic [15:0] seq;    // dispensed coins, first coin most significant
    logic        exp_short;
    logic [15:0] exp_rem;
    logic [7:0]  q;
    logic [7:0]  d;
    logic [7:0]  n;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int inv(input int d, input int c);
    if (d == 0) return int'(dut0.u_inv.cnt[c]);
    else        return int'(dut1.u_inv.cnt[c]);
  endfunction

  task automatic restock(input int d, input coin_t c, input logic [7:0] n);
    @(negedge clk);
    rsv[d] = 1'b1; rsc[d] = c; rsn[d] = n;
    @(negedge clk);
    rsv[d] = 1'b0;
  endtask

  task automatic do_refund(input int d, input logic [15:0] amt, input int exp_n,
                           input logic [15:0] exp_seq, input logic exp_short,
                           input logic [15:0] exp_rem,
                           input int eq, input int ed, input int en);
    int n = 0;
    int first = -1;
    logic [15:0] seq = '0;
    logic fin = 1'b0;
    @(negedge clk);
    req[d] = 1'b1; amt_i[d] = amt;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      req[d] = 1'b0;
      if (first < 0 && (cv[d] || dn[d])) first = k;
      if (cv[d] && rdy[d]) begin
        seq = {seq[13:0], co[d]};
        n++;
      end
      if (dn[d]) begin
        fin = 1'b1;
        break;
      end
    end
    chk("done_seen", fin, 1);
    chk("first_latency", first, 2);
    chk("coin_count", n, exp_n);
    chk("coin_seq", seq, exp_seq);
    chk("short", sh[d], exp_short);
    chk("remaining", rem[d], exp_rem);
    chk("inv_q", inv(d, 2), eq);
    chk("inv_d", inv(d, 1), ed);
    chk("inv_n", inv(d, 0), en);
    @(negedge clk);
    chk("done_pulse_len", dn[d], 0);
    chk("busy_after", bsy[d], 0);
  endtask

  task automatic check_reset(input int d, input int init);
    chk("rst_valid", cv[d], 0);
    chk("rst_busy", bsy[d], 0);
    chk("rst_done", dn[d], 0);
    chk("rst_short", sh[d], 0);
    chk("rst_fault", flt[d], 0);
    chk("rst_rem", rem[d], 0);
    chk("rst_coin", co[d], NICKEL);
    for (int c = 0; c < 3; c++) chk("rst_inv", inv(d, c), init);
  endtask

  initial begin
    int cnt;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req[d] = 1'b0; amt_i[d] = '0; rsv[d] = 1'b0;
      rsc[d] = NICKEL; rsn[d] = '0; rdy[d] = 1'b1;
    end

    vecs[0] = '{16'd65, 4'd4, 16'({QUARTER, QUARTER, DIME, NICKEL}), 1'b0, 16'd0, 8'd18, 8'd19, 8'd19};
    vecs[1] = '{16'd0,  4'd0, 16'd0, 1'b0, 16'd0, 8'd18, 8'd19, 8'd19};
    vecs[2] = '{16'd40, 4'd3, 16'({QUARTER, DIME, NICKEL}), 1'b0, 16'd0, 8'd17, 8'd18, 8'd18};
    vecs[3] = '{16'd3,  4'd0, 16'd0, 1'b1, 16'd3, 8'd17, 8'd18, 8'd18};
    vecs[4] = '{16'd30, 4'd2, 16'({QUARTER, NICKEL}), 1'b0, 16'd0, 8'd16, 8'd18, 8'd17};
    vecs[5] = '{16'd12, 4'd1, 16'({DIME}), 1'b1, 16'd2, 8'd16, 8'd17, 8'd17};
    vecs[6] = '{16'd95, 4'd5, 16'({QUARTER, QUARTER, QUARTER, DIME, DIME}), 1'b0, 16'd0, 8'd13, 8'd15, 8'd17};

    #12;
    check_reset(0, 20);
    check_reset(1, 1);
    @(negedge clk);
    rst[0] = 1'b1; rst[1] = 1'b1;

    for (int i = 0; i < 7; i++)
      do_refund(0, vecs[i].amt, int'(vecs[i].ncoins), vecs[i].seq, vecs[i].exp_short,
                vecs[i].exp_rem, int'(vecs[i].q), int'(vecs[i].d), int'(vecs[i].n));

    // Backpressure: DIME held stable for 5 refused cycles, then one transfer.
    rdy[0] = 1'b0;
    @(negedge clk); req[0] = 1'b1; amt_i[0] = 16'd10;
    @(negedge clk); req[0] = 1'b0;
    for (int i = 0; i < 10 && !cv[0]; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", cv[0], 1);
      chk("bp_coin", co[0], DIME);
      @(negedge clk);
    end
    chk("bp_valid_acc", cv[0], 1);
    chk("bp_coin_acc", co[0], DIME);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_single_xfer", cv[0], 0);
    chk("bp_done_early", dn[0], 0);
    @(negedge clk);
    chk("bp_done", dn[0], 1);
    chk("bp_rem", rem[0], 0);
    chk("bp_inv_d", inv(0, 1), 14);

    restock(0, QUARTER, 8'd187);
    chk("restock_q", inv(0, 2), 200);
    restock(0, QUARTER, 8'd255);
    chk("restock_sat", inv(0, 2), 255);
    restock(0, DOLLAR, 8'd5);
    chk("dollar_ign_n", inv(0, 0), 17);
    chk("dollar_ign_d", inv(0, 1), 14);
    chk("dollar_ign_q", inv(0, 2), 255);

    // Single-coin stock: shortfall with residue, then refill paths.
    do_refund(1, 16'd100, 3, 16'({QUARTER, DIME, NICKEL}), 1'b1, 16'd60, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("short_held", sh[1], 1);
    restock(1, NICKEL, 8'd1);
    do_refund(1, 16'd7, 1, 16'({NICKEL}), 1'b1, 16'd2, 0, 0, 0);
    restock(1, QUARTER, 8'd1);
    rdy[1] = 1'b0;
    @(negedge clk); req[1] = 1'b1; amt_i[1] = 16'd25;
    @(negedge clk); req[1] = 1'b0;
    chk("short_cleared", sh[1], 0);
    for (int i = 0; i < 10 && !cv[1]; i++) @(negedge clk);
    chk("col_valid", cv[1], 1);
    rdy[1] = 1'b1; rsv[1] = 1'b1; rsc[1] = QUARTER; rsn[1] = 8'd4;
    @(negedge clk);
    rsv[1] = 1'b0;
    chk("col_inv_q", inv(1, 2), 4);
    @(negedge clk);
    chk("col_done", dn[1], 1);
    chk("col_rem", rem[1], 0);
    chk("col_short", sh[1], 0);

    // Hopper never accepts: timeout after 255 presented cycles.
    rdy[0] = 1'b0;
    @(negedge clk); req[0] = 1'b1; amt_i[0] = 16'd5;
    @(negedge clk); req[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400 && !flt[0]; i++) begin
      if (cv[0]) cnt++;
      @(negedge clk);
    end
    chk("to_wait_cycles", cnt, 255);
    chk("to_fault", flt[0], 1);
    chk("to_valid", cv[0], 0);
    chk("to_busy", bsy[0], 1);
    @(negedge clk); req[0] = 1'b1; amt_i[0] = 16'd50;
    @(negedge clk); req[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_req_ign_fault", flt[0], 1);
    chk("to_req_ign_rem", rem[0], 5);
    chk("to_req_ign_valid", cv[0], 0);
    restock(0, NICKEL, 8'd2);
    chk("to_restock", inv(0, 0), 19);
    #3 rst[0] = 1'b0;
    #1 check_reset(0, 20);
    @(negedge clk); rst[0] = 1'b1; rdy[0] = 1'b1;

    // Reset while a coin is on offer, then a clean payout.
    rdy[0] = 1'b0;
    @(negedge clk); req[0] = 1'b1; amt_i[0] = 16'd65;
    @(negedge clk); req[0] = 1'b0;
    for (int i = 0; i < 10 && !cv[0]; i++) @(negedge clk);
    chk("mid_valid", cv[0], 1);
    #2 rst[0] = 1'b0;
    #1 check_reset(0, 20);
    @(negedge clk); rst[0] = 1'b1; rdy[0] = 1'b1;
    do_refund(0, 16'd25, 1, 16'({QUARTER}), 1'b0, 16'd0, 19, 20, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
